ex_mem_pipe_stage: RTL and testbench

Parametrised EX→MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer. It replaces the single-stall register with a stage that absorbs one beat of downstream back-pressure, so `in_ready` is never a combinational function of `out_ready`. It also adds explicit flush, sticky halt capture and an occupancy count. It sits between the EX stage (upstream) and the data-memory interface (downstream).

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_slot.sv | 44 ++++
 rtl/ex_mem_pipe_stage.sv | 108 ++++++++++
 tb/tb_ex_mem_pipe_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the EX->MEM pipeline stage.
// The payload struct describes the default core; the stage itself packs flat vectors so it stays parametric.
package pipe_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RADDR_W = 4;
  localparam int DEF_CTRL_W  = 6;

  // Bit positions inside the control bundle of the default core.
  localparam int CTRL_MEMRD = 0;
  localparam int CTRL_MEMWR = 1;
  localparam int CTRL_M2R   = 2;
  localparam int CTRL_REGWR = 3;
  localparam int CTRL_LLB   = 4;
  localparam int CTRL_LHB   = 5;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0]  ctrl;
    logic [DEF_DATA_W-1:0]  alu;
    logic [DEF_DATA_W-1:0]  wdata;
    logic [DEF_RADDR_W-1:0] waddr;
    logic                   hlt;
  } exmem_payload_t;

  localparam int PAY_W = $bits(exmem_payload_t);

  function automatic int pay_width(input int ctrl_w, input int data_w, input int raddr_w);
    return ctrl_w + 2 * data_w + raddr_w + 1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a valid bit plus payload, with load and clear (clear wins).
// valid_nxt exposes the value the valid flop takes at the next edge.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic         valid_nxt,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid     = valid_q;
  assign valid_nxt = valid_d;
  assign data      = data_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM stage with a main/skid entry pair so in_ready is a flop, never a path from out_ready.
// Handshake: a beat moves on a cycle where valid and ready are both high; valid never waits on ready.
module ex_mem_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CTRL_W  = DEF_CTRL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic               in_hlt,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_alu,
  output logic [DATA_W-1:0]  out_wdata,
  output logic [RADDR_W-1:0] out_waddr,
  output logic               out_hlt,
  output logic               hlt_seen,
  output logic [1:0]         occupancy
);

  localparam int SLOT_W = pay_width(CTRL_W, DATA_W, RADDR_W);

  logic [SLOT_W-1:0] in_pay, main_d, main_data, skid_data, head;
  logic main_v, main_v_nxt, main_load, main_clear;
  logic skid_v, skid_v_nxt, skid_load, skid_clear;
  logic accept, emit;
  logic in_ready_q, in_ready_d;
  logic hlt_acc_q, hlt_acc_d;
  logic hlt_seen_q, hlt_seen_d;
  logic [1:0] occ_q, occ_d;

  assign in_pay = {in_ctrl, in_alu, in_wdata, in_waddr, in_hlt};

  always_comb begin
    accept = in_valid & in_ready_q & ~flush;
    emit   = main_v & out_ready;
    // skid always drains into main first; a skid entry implies in_ready was low, so no accept competes.
    main_load  = (emit & skid_v) | (accept & (~main_v | emit));
    main_d     = skid_v ? skid_data : in_pay;
    main_clear = flush | (emit & ~skid_v & ~accept);
    skid_load  = accept & main_v & ~emit;
    skid_clear = flush | (emit & skid_v);
  end

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load),
    .clear     (main_clear),
    .d         (main_d),
    .valid     (main_v),
    .valid_nxt (main_v_nxt),
    .data      (main_data)
  );

  pipe_slot #(.W(SLOT_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .d         (in_pay),
    .valid     (skid_v),
    .valid_nxt (skid_v_nxt),
    .data      (skid_data)
  );

  always_comb begin
    hlt_acc_d  = hlt_acc_q | (accept & in_hlt);
    // An emit in a flush cycle is still delivered, so the halt is recorded regardless of flush.
    hlt_seen_d = hlt_seen_q | (emit & main_data[0]);
    in_ready_d = ~skid_v_nxt & ~hlt_acc_d;
    occ_d      = {1'b0, main_v_nxt} + {1'b0, skid_v_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b1;
      hlt_acc_q  <= 1'b0;
      hlt_seen_q <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      in_ready_q <= in_ready_d;
      hlt_acc_q  <= hlt_acc_d;
      hlt_seen_q <= hlt_seen_d;
      occ_q      <= occ_d;
    end
  end

  // Payload is forced to zero when idle so MEM never sees a stale MemWrite.
  assign head = main_v ? main_data : '0;
  assign {out_ctrl, out_alu, out_wdata, out_waddr, out_hlt} = head;

  assign out_valid = main_v;
  assign in_ready  = in_ready_q;
  assign hlt_seen  = hlt_seen_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: a two-deep FIFO reference model predicts every output each cycle.
module tb_ex_mem_pipe_stage;
  import pipe_pkg::*;

  localparam int OBS_W = 5 + PAY_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_hlt = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [5:0]  in_ctrl = '0;
  logic [15:0] in_alu = '0, in_wdata = '0;
  logic [3:0]  in_waddr = '0;
  logic        in_ready, out_valid, out_hlt, hlt_seen;
  logic [5:0]  out_ctrl;
  logic [15:0] out_alu, out_wdata;
  logic [3:0]  out_waddr;
  logic [1:0]  occupancy;
  logic [OBS_W-1:0] obs;

  always #5 clk = ~clk;

  ex_mem_pipe_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wdata(in_wdata), .in_waddr(in_waddr), .in_hlt(in_hlt),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_alu(out_alu), .out_wdata(out_wdata), .out_waddr(out_waddr),
    .out_hlt(out_hlt), .hlt_seen(hlt_seen), .occupancy(occupancy)
  );

  assign obs = {out_valid, in_ready, occupancy, hlt_seen, out_ctrl, out_alu, out_wdata, out_waddr, out_hlt};

  // Reference model state: the beats held, in order, plus halt flags.
  logic [PAY_W-1:0] exp_q[$];
  logic [15:0]      model_deliv_q[$];
  logic [15:0]      dut_deliv_q[$];
  bit               hlt_acc_m, hlt_seen_m;
  int               checks = 0;
  int               errors = 0;

  function automatic logic [OBS_W-1:0] exp_obs();
    logic [PAY_W-1:0] head;
    logic v, rdy;
    logic [1:0] occ;
    v    = exp_q.size() > 0;
    head = v ? exp_q[0] : '0;
    rdy  = (exp_q.size() < 2) && !hlt_acc_m;
    occ  = 2'(exp_q.size());
    return {v, rdy, occ, hlt_seen_m, head};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hlt_acc_m  = 1'b0;
    hlt_seen_m = 1'b0;
  endtask

  task automatic set_in(input bit v, input logic [15:0] alu, input bit hlt, input bit ordy, input bit fl);
    in_valid  = v;
    in_alu    = alu;
    in_hlt    = hlt;
    out_ready = ordy;
    flush     = fl;
    in_ctrl   = 6'($urandom_range(0, 63));
    in_wdata  = 16'($urandom_range(0, 65535));
    in_waddr  = 4'($urandom_range(0, 15));
  endtask

  // Advance one clock edge, updating the model from the rules applied to the current inputs.
  task automatic tick();
    bit rdy_m, acc, em;
    exmem_payload_t p;
    rdy_m = (exp_q.size() < 2) && !hlt_acc_m;
    acc   = in_valid && rdy_m && !flush;
    em    = (exp_q.size() > 0) && out_ready;
    if (out_valid && out_ready) dut_deliv_q.push_back(out_alu);
    if (em) begin
      p = exmem_payload_t'(exp_q.pop_front());
      model_deliv_q.push_back(p.alu);
      if (p.hlt) hlt_seen_m = 1'b1;
    end
    if (flush) exp_q.delete();
    else if (acc) begin
      exp_q.push_back({in_ctrl, in_alu, in_wdata, in_waddr, in_hlt});
      if (in_hlt) hlt_acc_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 16'h0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_obs()) begin
      errors++;
      $display("FAIL reset_held got %h want %h", obs, exp_obs());
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_obs()) begin
      errors++;
      $display("FAIL reset_released got %h want %h", obs, exp_obs());
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 6; i++) begin
      set_in(i < 3, (i < 3) ? 16'(16 * (i + 1)) : 16'h0, 0, 1, 0);
      tick();
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL stream step %0d got %h want %h", i, obs, exp_obs());
      end
      checks++;
      if (occupancy > 2'd1) begin
        errors++;
        $display("FAIL stream_occ step %0d got %0d want <=1", i, occupancy);
      end
    end
  endtask

  task automatic test_backpressure();
    bit v_t[6]      = '{1, 1, 0, 0, 0, 0};
    bit r_t[6]      = '{1, 0, 0, 1, 1, 1};
    logic [15:0] a_t[6] = '{16'hA000, 16'hA001, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 6; i++) begin
      set_in(v_t[i], a_t[i], 0, r_t[i], 0);
      tick();
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL backpressure step %0d got %h want %h", i, obs, exp_obs());
      end
      if (i == 2) begin
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_alu !== 16'hA000) begin
          errors++;
          $display("FAIL bp_full got occ=%0d rdy=%b alu=%h want occ=2 rdy=0 alu=a000",
                   occupancy, in_ready, out_alu);
        end
      end
    end
  endtask

  task automatic test_flush_full();
    bit v_t[7]      = '{1, 1, 1, 0, 1, 1, 0};
    bit r_t[7]      = '{0, 0, 0, 1, 0, 0, 1};
    bit f_t[7]      = '{0, 0, 1, 0, 0, 1, 0};
    logic [15:0] a_t[7] = '{16'h1111, 16'h2222, 16'hBEEF, 16'h0, 16'h3333, 16'hBEEF, 16'h0};
    for (int i = 0; i < 7; i++) begin
      set_in(v_t[i], a_t[i], 0, r_t[i], f_t[i]);
      tick();
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL flush_full step %0d got %h want %h", i, obs, exp_obs());
      end
      if (f_t[i]) begin
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
          errors++;
          $display("FAIL flush_clears got valid=%b occ=%0d want valid=0 occ=0", out_valid, occupancy);
        end
      end
    end
    foreach (dut_deliv_q[k]) begin
      checks++;
      if (dut_deliv_q[k] === 16'hBEEF) begin
        errors++;
        $display("FAIL flush_drop got beef delivered at %0d want never", k);
      end
    end
  endtask

  task automatic test_flush_emit();
    bit v_t[5]      = '{1, 1, 0, 0, 0};
    bit r_t[5]      = '{0, 0, 1, 1, 1};
    bit f_t[5]      = '{0, 0, 1, 0, 0};
    logic [15:0] a_t[5] = '{16'h1234, 16'h5678, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 5; i++) begin
      set_in(v_t[i], a_t[i], 0, r_t[i], f_t[i]);
      tick();
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL flush_emit step %0d got %h want %h", i, obs, exp_obs());
      end
    end
    checks++;
    if (dut_deliv_q.size() == 0 || dut_deliv_q[dut_deliv_q.size()-1] !== 16'h1234) begin
      errors++;
      $display("FAIL flush_emit_deliv got %0d beats want last=1234", dut_deliv_q.size());
    end
    foreach (dut_deliv_q[k]) begin
      checks++;
      if (dut_deliv_q[k] === 16'h5678) begin
        errors++;
        $display("FAIL flush_emit_skid got 5678 delivered at %0d want never", k);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, 16'($urandom_range(0, 65535)), 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      tick();
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL random cycle %0d got %h want %h", i, obs, exp_obs());
      end
    end
  endtask

  task automatic test_async_reset();
    logic [OBS_W-1:0] rst_obs;
    set_in(1, 16'hC001, 0, 0, 0);
    tick();
    set_in(1, 16'hC002, 0, 0, 0);
    tick();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL async_prefill got occ=%0d want 2", occupancy);
    end
    set_in(1, 16'hC003, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_obs = {1'b0, 1'b1, 2'd0, 1'b0, {PAY_W{1'b0}}};
    checks++;
    if (obs !== rst_obs) begin
      errors++;
      $display("FAIL async_reset got %h want %h", obs, rst_obs);
    end
    model_reset();
    set_in(0, 16'h0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_obs()) begin
      errors++;
      $display("FAIL async_release got %h want %h", obs, exp_obs());
    end
  endtask

  task automatic test_halt();
    bit v_t[7] = '{1, 1, 1, 1, 1, 0, 0};
    bit h_t[7] = '{1, 0, 0, 0, 0, 0, 0};
    bit f_t[7] = '{0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      set_in(v_t[i], (i == 0) ? 16'h7777 : 16'h5555, h_t[i], 1, f_t[i]);
      tick();
      checks++;
      if (obs !== exp_obs()) begin
        errors++;
        $display("FAIL halt step %0d got %h want %h", i, obs, exp_obs());
      end
    end
    checks++;
    if (hlt_seen !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL halt_sticky got seen=%b rdy=%b want seen=1 rdy=0", hlt_seen, in_ready);
    end
    foreach (dut_deliv_q[k]) begin
      checks++;
      if (dut_deliv_q[k] === 16'h5555) begin
        errors++;
        $display("FAIL halt_refuse got 5555 delivered at %0d want never", k);
      end
    end
  endtask

  task automatic test_delivery_order();
    checks++;
    if (dut_deliv_q.size() != model_deliv_q.size()) begin
      errors++;
      $display("FAIL deliv_count got %0d want %0d", dut_deliv_q.size(), model_deliv_q.size());
    end else begin
      foreach (model_deliv_q[k]) begin
        checks++;
        if (dut_deliv_q[k] !== model_deliv_q[k]) begin
          errors++;
          $display("FAIL deliv_order idx %0d got %h want %h", k, dut_deliv_q[k], model_deliv_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_flush_emit();
    test_random();
    test_async_reset();
    test_halt();
    test_delivery_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
